// File: rtl/mc_ctrl.sv
// Moore FSM controller for the multi-cycle MIPS datapath. It sequences the shared ALU
// and the shared memory, and guards every memory handshake with an optional timeout.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_en,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       err_timeout,
    output logic [3:0] state
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_RTEX   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);
    // The counter reaches MEM_TIMEOUT on the edge that ends this count.
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    logic [3:0] next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       timeout;
    logic       access_entry;

    assign timeout = TIMEOUT_EN && mem_en && !mem_ready && (wait_cnt == WAIT_LAST);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTEX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_RTEX:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;
        endcase
        if (timeout) next_state = S_FETCH;
    end

    assign access_entry = (next_state != state) &&
                          ((next_state == S_FETCH) || (next_state == S_MEMRD) ||
                           (next_state == S_MEMWR));

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (timeout || access_entry || (mem_en && mem_ready)) begin
            wait_cnt_next = '0;
        end else if (mem_en && !mem_ready && (wait_cnt != 8'hFF)) begin
            wait_cnt_next = wait_cnt + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RESET;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            if (timeout) err_timeout <= 1'b1;
        end
    end

    always_comb begin
        mem_en     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_en  = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (!(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J})) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_en = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_en     = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle tables of inputs and hand-derived state/control
// values covering every instruction class, memory waits, illegal opcodes and timeout.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_en, iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst, memtoreg, regwrite, instr_done, illegal_op, err_timeout;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_en(mem_en), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .instr_done(instr_done), .illegal_op(illegal_op),
        .err_timeout(err_timeout), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {mem_en,iord,memwrite,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,aluop,
    //  regdst,memtoreg,regwrite,instr_done,illegal_op}
    logic [17:0] ctrl;
    assign ctrl = {mem_en, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
                   alusrcb, aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};

    localparam logic [17:0] C_IDLE    = 18'b0;
    localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] C_FETCH_W = 18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_1_1;
    localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_00_0_00_00_0_1_1_1_0;
    localparam logic [17:0] C_MEMWR_W = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [17:0] C_MEMWR_R = 18'b1_1_1_0_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [17:0] C_RTEX    = 18'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_0_00_0_00_00_1_0_1_1_0;
    localparam logic [17:0] C_BEQ     = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_1_0;
    localparam logic [17:0] C_ADDIEX  = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_00_0_00_00_0_0_1_1_0;
    localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_1_0;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // One row per clock cycle: inputs applied during the cycle and expected outputs.
    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic        err;
    } row_t;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; op = OP_R; mem_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({state, ctrl, err_timeout} !== {4'd0, C_IDLE, 1'b0}) begin
                fails++;
                $display("FAIL reset[%0d]: state=%0d ctrl=%b err=%b, expected state=0 ctrl=%b err=0",
                         i, state, ctrl, err_timeout, C_IDLE);
            end
            next_cycle();
        end
        rst = 1'b1;
        #1;
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("FAIL reset_release: state=%0d, expected 0", state);
        end
        next_cycle();
        tests++;
        if ({state, ctrl} !== {4'd1, C_FETCH_R}) begin
            fails++;
            $display("FAIL reset_to_fetch: state=%0d ctrl=%b, expected state=1 ctrl=%b",
                     state, ctrl, C_FETCH_R);
        end
        mem_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_lw();
        row_t rows [13];
        rows = '{
            '{OP_LW, 1'b1, 4'd1, C_FETCH_R, 1'b0},
            '{OP_LW, 1'b0, 4'd2, C_DECODE,  1'b0},
            '{OP_LW, 1'b0, 4'd3, C_MEMADR,  1'b0},
            '{OP_LW, 1'b1, 4'd4, C_MEMRD,   1'b0},
            '{OP_LW, 1'b0, 4'd5, C_MEMWB,   1'b0},
            '{OP_LW, 1'b1, 4'd1, C_FETCH_R, 1'b0},
            '{OP_LW, 1'b0, 4'd2, C_DECODE,  1'b0},
            '{OP_LW, 1'b0, 4'd3, C_MEMADR,  1'b0},
            '{OP_LW, 1'b0, 4'd4, C_MEMRD,   1'b0},
            '{OP_LW, 1'b0, 4'd4, C_MEMRD,   1'b0},
            '{OP_LW, 1'b1, 4'd4, C_MEMRD,   1'b0},
            '{OP_LW, 1'b0, 4'd5, C_MEMWB,   1'b0},
            '{OP_LW, 1'b0, 4'd1, C_FETCH_W, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            op = rows[i].op; mem_ready = rows[i].rdy;
            #1;
            tests++;
            if ({state, ctrl, err_timeout} !== {rows[i].st, rows[i].ctrl, rows[i].err}) begin
                fails++;
                $display("FAIL lw[%0d]: state=%0d ctrl=%b err=%b, expected state=%0d ctrl=%b err=%b",
                         i, state, ctrl, err_timeout, rows[i].st, rows[i].ctrl, rows[i].err);
            end
            next_cycle();
        end
    endtask

    task automatic test_sw_wait();
        row_t rows [8];
        rows = '{
            '{OP_SW, 1'b1, 4'd1, C_FETCH_R, 1'b0},
            '{OP_SW, 1'b1, 4'd2, C_DECODE,  1'b0},
            '{OP_SW, 1'b0, 4'd3, C_MEMADR,  1'b0},
            '{OP_SW, 1'b0, 4'd6, C_MEMWR_W, 1'b0},
            '{OP_SW, 1'b0, 4'd6, C_MEMWR_W, 1'b0},
            '{OP_SW, 1'b0, 4'd6, C_MEMWR_W, 1'b0},
            '{OP_SW, 1'b1, 4'd6, C_MEMWR_R, 1'b0},
            '{OP_SW, 1'b0, 4'd1, C_FETCH_W, 1'b0}
        };
        for (int i = 0; i < 8; i++) begin
            op = rows[i].op; mem_ready = rows[i].rdy;
            #1;
            tests++;
            if ({state, ctrl, err_timeout} !== {rows[i].st, rows[i].ctrl, rows[i].err}) begin
                fails++;
                $display("FAIL sw[%0d]: state=%0d ctrl=%b err=%b, expected state=%0d ctrl=%b err=%b",
                         i, state, ctrl, err_timeout, rows[i].st, rows[i].ctrl, rows[i].err);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        row_t rows [15];
        rows = '{
            '{OP_R,   1'b1, 4'd1,  C_FETCH_R, 1'b0},
            '{OP_R,   1'b1, 4'd2,  C_DECODE,  1'b0},
            '{OP_LW,  1'b1, 4'd7,  C_RTEX,    1'b0},
            '{OP_SW,  1'b1, 4'd8,  C_ALUWB,   1'b0},
            '{OP_BEQ, 1'b1, 4'd1,  C_FETCH_R, 1'b0},
            '{OP_BEQ, 1'b1, 4'd2,  C_DECODE,  1'b0},
            '{OP_J,   1'b1, 4'd9,  C_BEQ,     1'b0},
            '{OP_J,   1'b1, 4'd1,  C_FETCH_R, 1'b0},
            '{OP_J,   1'b1, 4'd2,  C_DECODE,  1'b0},
            '{OP_LW,  1'b1, 4'd12, C_JUMP,    1'b0},
            '{OP_ADI, 1'b1, 4'd1,  C_FETCH_R, 1'b0},
            '{OP_ADI, 1'b1, 4'd2,  C_DECODE,  1'b0},
            '{OP_SW,  1'b1, 4'd10, C_ADDIEX,  1'b0},
            '{OP_BAD, 1'b1, 4'd11, C_ADDIWB,  1'b0},
            '{OP_R,   1'b0, 4'd1,  C_FETCH_W, 1'b0}
        };
        for (int i = 0; i < 15; i++) begin
            op = rows[i].op; mem_ready = rows[i].rdy;
            #1;
            tests++;
            if ({state, ctrl, err_timeout} !== {rows[i].st, rows[i].ctrl, rows[i].err}) begin
                fails++;
                $display("FAIL b2b[%0d]: state=%0d ctrl=%b err=%b, expected state=%0d ctrl=%b err=%b",
                         i, state, ctrl, err_timeout, rows[i].st, rows[i].ctrl, rows[i].err);
            end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        row_t rows [6];
        rows = '{
            '{OP_BAD, 1'b1, 4'd1, C_FETCH_R, 1'b0},
            '{OP_BAD, 1'b0, 4'd2, C_DEC_ILL, 1'b0},
            '{OP_BAD, 1'b0, 4'd1, C_FETCH_W, 1'b0},
            '{OP_JAL, 1'b1, 4'd1, C_FETCH_R, 1'b0},
            '{OP_JAL, 1'b0, 4'd2, C_DEC_ILL, 1'b0},
            '{OP_JAL, 1'b0, 4'd1, C_FETCH_W, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            op = rows[i].op; mem_ready = rows[i].rdy;
            #1;
            tests++;
            if ({state, ctrl, err_timeout} !== {rows[i].st, rows[i].ctrl, rows[i].err}) begin
                fails++;
                $display("FAIL illegal[%0d]: state=%0d ctrl=%b err=%b, expected state=%0d ctrl=%b err=%b",
                         i, state, ctrl, err_timeout, rows[i].st, rows[i].ctrl, rows[i].err);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        row_t rows [16];
        rows = '{
            '{OP_J,  1'b1, 4'd1,  C_FETCH_R, 1'b0},
            '{OP_J,  1'b0, 4'd2,  C_DECODE,  1'b0},
            '{OP_J,  1'b0, 4'd12, C_JUMP,    1'b0},
            '{OP_J,  1'b0, 4'd1,  C_FETCH_W, 1'b0},
            '{OP_J,  1'b0, 4'd1,  C_FETCH_W, 1'b0},
            '{OP_J,  1'b0, 4'd1,  C_FETCH_W, 1'b0},
            '{OP_J,  1'b0, 4'd1,  C_FETCH_W, 1'b0},
            '{OP_LW, 1'b0, 4'd1,  C_FETCH_W, 1'b1},
            '{OP_LW, 1'b1, 4'd1,  C_FETCH_R, 1'b1},
            '{OP_LW, 1'b0, 4'd2,  C_DECODE,  1'b1},
            '{OP_LW, 1'b0, 4'd3,  C_MEMADR,  1'b1},
            '{OP_LW, 1'b0, 4'd4,  C_MEMRD,   1'b1},
            '{OP_LW, 1'b0, 4'd4,  C_MEMRD,   1'b1},
            '{OP_LW, 1'b0, 4'd4,  C_MEMRD,   1'b1},
            '{OP_LW, 1'b0, 4'd4,  C_MEMRD,   1'b1},
            '{OP_LW, 1'b0, 4'd1,  C_FETCH_W, 1'b1}
        };
        for (int i = 0; i < 16; i++) begin
            op = rows[i].op; mem_ready = rows[i].rdy;
            #1;
            tests++;
            if ({state, ctrl, err_timeout} !== {rows[i].st, rows[i].ctrl, rows[i].err}) begin
                fails++;
                $display("FAIL timeout[%0d]: state=%0d ctrl=%b err=%b, expected state=%0d ctrl=%b err=%b",
                         i, state, ctrl, err_timeout, rows[i].st, rows[i].ctrl, rows[i].err);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if ({state, ctrl, err_timeout} !== {4'd0, C_IDLE, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: state=%0d ctrl=%b err=%b, expected state=0 ctrl=%b err=0",
                     state, ctrl, err_timeout, C_IDLE);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        tests++;
        if ({state, ctrl, err_timeout} !== {4'd1, C_FETCH_W, 1'b0}) begin
            fails++;
            $display("FAIL post_reset_fetch: state=%0d ctrl=%b err=%b, expected state=1 ctrl=%b err=0",
                     state, ctrl, err_timeout, C_FETCH_W);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Moore FSM controller for the multi-cycle MIPS datapath. Sequences one shared ALU and one shared instruction/data memory through fetch, decode, execute, memory and writeback steps.
- Supports the same opcode set as the single-cycle decoder: R-type, lw, sw, beq, addi, j.
- Talks to memory over a req/ready handshake, so memory latency is variable.
- Sits between the instruction register (supplies op) and the datapath muxes/enables.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles for mem_ready per access (1..255); 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  6  opcode from instruction register; only sampled in DECODE/MEMADR.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_en  out  1  memory request; held until mem_ready.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  write strobe; valid while mem_en=1.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  conditional PC load (datapath ANDs with zero).
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  2  00 = add, 01 = sub, 10 = use funct.
- regdst  out  1  register write address: 0 = rt, 1 = rd.
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- err_timeout  out  1  sticky; set on memory timeout, cleared only by reset.
- state  out  4  current state code, for debug.

Behaviour:
- State codes: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEX=7, ALUWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Reset (rst=0, asynchronous): state=RESET, wait counter=0, err_timeout=0.
  - Every output is 0 in RESET except state.
  - RESET -> FETCH on the first clock edge after rst deasserts.
  - Reset asserted mid-access: state returns to RESET and mem_en drops immediately.
- All control outputs are combinational decodes of the state register, plus mem_ready where noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_en=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready.
  - Stay in FETCH while mem_ready=0. When mem_ready=1, go to DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (precomputes branch target).
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other op: illegal_op=1, instr_done=1, -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op=100011 -> MEMRD, otherwise -> MEMWR.
- MEMRD: mem_en=1, iord=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, instr_done=1. -> FETCH.
- MEMWR: mem_en=1, iord=1, memwrite=1. Wait for mem_ready; then instr_done=1 in the completing cycle and -> FETCH.
- RTEX: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01, instr_done=1. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. -> FETCH.
- JUMP: pcwrite=1, pcsrc=10, instr_done=1. -> FETCH.
- Instruction latency with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory wait cycle adds one.
- Wait counter (8-bit):
  - Clears on entry to FETCH, MEMRD or MEMWR, and on mem_ready.
  - Increments each cycle mem_en=1 and mem_ready=0, saturating at 255.
- Timeout: if MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready=0:
  - err_timeout <= 1 and state -> FETCH, abandoning the access. No irwrite, pcwrite, memwrite or regwrite occurs for the abandoned access.
  - A timeout in FETCH re-fetches from the same PC.
- mem_ready while mem_en=0 is ignored.
- op changes outside DECODE/MEMADR have no effect.

Test Plan:
- rst low for 3 cycles, then high, mem_ready tied 1 -> state 0 then 1. All outputs 0 during reset. At the FETCH edge irwrite=pcwrite=1, alusrcb=01.
- op=100011, mem_ready=1 -> states 1,2,3,4,5,1. MEMWB shows regwrite=1, memtoreg=1, regdst=0, instr_done=1. Total 5 cycles.
- op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=mem_en=iord=1 held 4 cycles. instr_done pulses once. Returns to FETCH. No regwrite at any point.
- op=000000, then 000100, then 000010 -> R-type: aluop=10 in RTEX, regdst=1 in ALUWB. beq: branch=1, pcsrc=01, aluop=01. j: pcwrite=1, pcsrc=10. Each ends in FETCH.
- op=111111 -> illegal_op and instr_done pulse in DECODE for 1 cycle. Next state FETCH. No regwrite or memwrite asserted.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 wait cycles state re-enters FETCH and err_timeout=1, staying 1. irwrite never asserts. Asserting rst clears err_timeout.
